// File: rtl/rt_pkg.sv
// rt_pkg: shared types for the frame-buffer scanout path: pixel word, FIFO entry and FSM states.
package rt_pkg;

    localparam int RT_WORD_LEN = 32;

    typedef logic [RT_WORD_LEN-1:0] pixel_t;

    // One FIFO slot: the pixel plus the sidebands that must stay aligned with it.
    typedef struct packed {
        pixel_t data;
        logic   user;
        logic   last;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } scan_state_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// rt_sync_fifo: generic synchronous FIFO with occupancy count and asynchronous active-low reset.
module rt_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && !w_full;
    assign o_data   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Storage is cleared on reset so the head word reads as zero while empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            assert (!(i_push && w_full));
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: walks the pixel RAM in raster order and streams pixels out through a 3-entry FIFO.
// Build macro FB_SCANOUT_TEST_PATTERN_EN adds a test_pattern input that substitutes {y,x} for RAM data.
module fb_scanout
    import rt_pkg::*;
#(
    parameter  int WORD_LEN = RT_WORD_LEN,
    parameter  int H_RES    = 16,
    parameter  int V_RES    = 16,
    localparam int DEPTH    = H_RES * V_RES,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    input  logic                test_pattern,
`endif
    output logic                busy,
    output logic                frame_done,
    output logic                enb,
    output logic [ADDR_W-1:0]   addrb,
    input  logic [WORD_LEN-1:0] dob,
    output logic [WORD_LEN-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tuser,
    output logic                m_tlast
);

    localparam int XW         = $clog2(H_RES);
    localparam int YW         = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int FIFO_DEPTH = 3;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    scan_state_t       r_state;
    scan_state_t       w_stateNext;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_inflight;
    logic              r_user1;
    logic              r_last1;
    logic              w_enb;
    logic              w_frameDone;
    logic              w_pop;
    logic              w_empty;
    logic              w_xLast;
    logic              w_lastAddr;
    logic [CW-1:0]     w_count;
    logic [2:0]        w_occupancy;
    fifo_entry_t       w_entryIn;
    fifo_entry_t       w_head;

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    logic              r_patMode;
    logic [15:0]       r_pat1;
`endif

    assign w_xLast     = (r_x == XW'(H_RES - 1));
    assign w_lastAddr  = (r_rdAddr == ADDR_W'(DEPTH - 1));
    assign w_occupancy = 3'(w_count) + 3'(r_inflight);
    assign w_pop       = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A read is only issued when the FIFO can still absorb it after the one already in flight lands.
    always_comb begin
        w_stateNext = r_state;
        w_enb       = 1'b0;
        w_frameDone = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                w_enb = (w_occupancy < 3'd3);
                if (w_enb && w_lastAddr) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                w_frameDone = w_pop && (w_count == CW'(1)) && !r_inflight;
                if (w_frameDone) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Sidebands are captured at issue time and ride alongside the read until dob arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdAddr   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
            r_user1    <= 1'b0;
            r_last1    <= 1'b0;
        end else begin
            r_inflight <= w_enb;
            if (w_enb) begin
                r_user1  <= (r_rdAddr == '0);
                r_last1  <= w_xLast;
                r_rdAddr <= w_lastAddr ? '0 : r_rdAddr + ADDR_W'(1);
                if (w_xLast) begin
                    r_x <= '0;
                    r_y <= (r_y == YW'(V_RES - 1)) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_patMode <= 1'b0;
            r_pat1    <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_patMode <= test_pattern;
            end
            if (w_enb) begin
                r_pat1 <= {8'(r_y), 8'(r_x)};
            end
        end
    end
`endif

    always_comb begin
        w_entryIn.data = pixel_t'(dob);
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        if (r_patMode) begin
            w_entryIn.data = pixel_t'(r_pat1);
        end
`endif
        w_entryIn.user = r_user1;
        w_entryIn.last = r_last1;
    end

    rt_sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (r_inflight),
        .i_data  (w_entryIn),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign busy       = (r_state != IDLE);
    assign frame_done = w_frameDone;
    assign enb        = w_enb;
    assign addrb      = r_rdAddr;
    assign m_tvalid   = !w_empty;
    assign m_tdata    = WORD_LEN'(w_head.data);
    assign m_tuser    = w_head.user;
    assign m_tlast    = w_head.last;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench for fb_scanout with behavioural 1-cycle-latency RAMs (mem[i]=i).
module tb_fb_scanout;

    localparam int AH = 4;
    localparam int AV = 2;
    localparam int AD = AH * AV;
    localparam int BH = 16;
    localparam int BV = 16;
    localparam int BD = BH * BV;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic        rst_n;
    logic        startA, busyA, doneA, enbA, treadyA, tvalidA, tuserA, tlastA;
    logic [2:0]  addrbA;
    logic [31:0] dobA, tdataA;
    logic        startB, busyB, doneB, enbB, treadyB, tvalidB, tuserB, tlastB;
    logic [7:0]  addrbB;
    logic [31:0] dobB, tdataB;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    logic        testPatternA;
    logic        testPatternB;
`endif

    logic [31:0] memA [AD];
    logic [31:0] memB [BD];
    exp_t        sbA [$];
    exp_t        sbB [$];
    exp_t        expA;
    exp_t        expB;
    int          popCntA   = 0;
    int          userCntB  = 0;
    int          lastCntB  = 0;
    logic        prevDoneA = 1'b0;

    fb_scanout #(.WORD_LEN(32), .H_RES(AH), .V_RES(AV)) dutA (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (startA),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        .test_pattern (testPatternA),
`endif
        .busy         (busyA),
        .frame_done   (doneA),
        .enb          (enbA),
        .addrb        (addrbA),
        .dob          (dobA),
        .m_tdata      (tdataA),
        .m_tvalid     (tvalidA),
        .m_tready     (treadyA),
        .m_tuser      (tuserA),
        .m_tlast      (tlastA)
    );

    fb_scanout #(.WORD_LEN(32), .H_RES(BH), .V_RES(BV)) dutB (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (startB),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        .test_pattern (testPatternB),
`endif
        .busy         (busyB),
        .frame_done   (doneB),
        .enb          (enbB),
        .addrb        (addrbB),
        .dob          (dobB),
        .m_tdata      (tdataB),
        .m_tvalid     (tvalidB),
        .m_tready     (treadyB),
        .m_tuser      (tuserB),
        .m_tlast      (tlastB)
    );

    initial begin
        for (int i = 0; i < AD; i++) memA[i] = 32'(i);
        for (int i = 0; i < BD; i++) memB[i] = 32'(i);
    end

    always @(posedge clk) begin
        if (enbA) dobA <= memA[addrbA];
        if (enbB) dobB <= memB[addrbB];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (failure %0d)", tag, observed, expected, failCount);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic pushFrameA(input bit pat);
        exp_t e;
        for (int i = 0; i < AD; i++) begin
            e.data = pat ? {16'd0, 8'(i / AH), 8'(i % AH)} : 32'(i);
            e.user = (i == 0);
            e.last = ((i % AH) == AH - 1);
            e.done = (i == AD - 1);
            sbA.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit expectFrame, input bit pat);
        startA = 1'b1;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        testPatternA = pat;
`endif
        if (expectFrame) pushFrameA(pat);
        nextCycle();
        startA = 1'b0;
    endtask

    task automatic waitFrameDoneA(input bit startAtDone, output int cycles);
        cycles = 0;
        #1;
        while (!doneA && cycles < 2000) begin
            nextCycle();
            #1;
            cycles++;
        end
        checkOutput("frameDoneSeenA", 32'(doneA), 32'd1);
        if (startAtDone) startA = 1'b1;
        nextCycle();
        startA = 1'b0;
        #1;
        checkOutput("busyAfterFrameA", 32'(busyA), 32'd0);
    endtask

    // Every valid cycle must show the scoreboard head; a handshake retires it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prevDoneA) checkOutput("busyCycleAfterDoneA", 32'(busyA), 32'd0);
            prevDoneA = doneA;
            if (tvalidA) begin
                if (sbA.size() == 0) begin
                    checkOutput("extraPixelA", 32'(sbA.size()), 32'd1);
                end else begin
                    expA = sbA[0];
                    checkOutput("tdataA", tdataA, expA.data);
                    checkOutput("tuserA", 32'(tuserA), 32'(expA.user));
                    checkOutput("tlastA", 32'(tlastA), 32'(expA.last));
                    if (treadyA) begin
                        checkOutput("frameDoneA", 32'(doneA), 32'(expA.done));
                        void'(sbA.pop_front());
                        popCntA++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && tvalidB && treadyB) begin
            if (sbB.size() == 0) begin
                checkOutput("extraPixelB", 32'(sbB.size()), 32'd1);
            end else begin
                expB = sbB.pop_front();
                checkOutput("tdataB", tdataB, expB.data);
                checkOutput("tuserB", 32'(tuserB), 32'(expB.user));
                checkOutput("tlastB", 32'(tlastB), 32'(expB.last));
                checkOutput("frameDoneB", 32'(doneB), 32'(expB.done));
                if (tuserB) userCntB++;
                if (tlastB) lastCntB++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   cyc;
        int   nEnb;
        int   base;
        exp_t e;

        rst_n   = 1'b0;
        startA  = 1'b0;
        startB  = 1'b0;
        treadyA = 1'b1;
        treadyB = 1'b1;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        testPatternA = 1'b0;
        testPatternB = 1'b0;
`endif
        #3;
        checkOutput("rstBusy",   32'(busyA),   32'd0);
        checkOutput("rstEnb",    32'(enbA),    32'd0);
        checkOutput("rstAddrb",  32'(addrbA),  32'd0);
        checkOutput("rstTvalid", 32'(tvalidA), 32'd0);
        checkOutput("rstTdata",  tdataA,       32'd0);
        checkOutput("rstTuser",  32'(tuserA),  32'd0);
        checkOutput("rstTlast",  32'(tlastA),  32'd0);
        checkOutput("rstDone",   32'(doneA),   32'd0);
        checkOutput("rstBusyB",  32'(busyB),   32'd0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] back-to-back frame with latency check");
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("firstEnb",     32'(enbA),    32'd1);
        checkOutput("firstAddrb",   32'(addrbA),  32'd0);
        checkOutput("validCycleN1", 32'(tvalidA), 32'd0);
        nextCycle();
        checkOutput("validCycleN2", 32'(tvalidA), 32'd0);
        nextCycle();
        checkOutput("validCycleN3", 32'(tvalidA), 32'd1);
        checkOutput("tuserCycleN3", 32'(tuserA),  32'd1);
        waitFrameDoneA(1'b0, cyc);
        checkOutput("backToBackCycles", 32'(cyc), 32'd7);
        checkOutput("enbAfterFrame",    32'(enbA), 32'd0);

        $display("[TB] downstream stall");
        treadyA = 1'b0;
        applyStimulus(1'b1, 1'b0);
        nEnb = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (enbA) nEnb++;
            nextCycle();
        end
        #1;
        checkOutput("stallReads",  32'(nEnb),    32'd3);
        checkOutput("stallEnb",    32'(enbA),    32'd0);
        checkOutput("stallValid",  32'(tvalidA), 32'd1);
        checkOutput("stallTdata",  tdataA,       32'd0);
        treadyA = 1'b1;
        waitFrameDoneA(1'b0, cyc);
        checkOutput("releaseCycles", 32'(cyc), 32'd7);

        $display("[TB] start during busy and on frame_done");
        applyStimulus(1'b1, 1'b0);
        repeat (3) nextCycle();
        applyStimulus(1'b0, 1'b0);
        waitFrameDoneA(1'b1, cyc);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("idleAfterDroppedStart", 32'(busyA), 32'd0);
        end
        checkOutput("scoreboardEmptyA", 32'(sbA.size()), 32'd0);
        applyStimulus(1'b1, 1'b0);
        waitFrameDoneA(1'b0, cyc);
        checkOutput("secondFrameCycles", 32'(cyc), 32'd9);

        $display("[TB] reset mid-frame");
        base = popCntA;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 100 && popCntA < base + 5; i++) nextCycle();
        checkOutput("pixelsBeforeReset", 32'(popCntA - base), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy",   32'(busyA),   32'd0);
        checkOutput("midRstEnb",    32'(enbA),    32'd0);
        checkOutput("midRstAddrb",  32'(addrbA),  32'd0);
        checkOutput("midRstTvalid", 32'(tvalidA), 32'd0);
        checkOutput("midRstTdata",  tdataA,       32'd0);
        checkOutput("midRstTuser",  32'(tuserA),  32'd0);
        checkOutput("midRstTlast",  32'(tlastA),  32'd0);
        checkOutput("midRstDone",   32'(doneA),   32'd0);
        sbA.delete();
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 1'b0);
        waitFrameDoneA(1'b0, cyc);
        checkOutput("restartCycles", 32'(cyc), 32'd9);

`ifdef FB_SCANOUT_TEST_PATTERN_EN
        $display("[TB] coordinate test pattern");
        applyStimulus(1'b1, 1'b1);
        waitFrameDoneA(1'b0, cyc);
        testPatternA = 1'b0;
        checkOutput("patternScoreboardEmpty", 32'(sbA.size()), 32'd0);
`endif

        $display("[TB] random backpressure over 16x16 frame");
        for (int i = 0; i < BD; i++) begin
            e.data = 32'(i);
            e.user = (i == 0);
            e.last = ((i % BH) == BH - 1);
            e.done = (i == BD - 1);
            sbB.push_back(e);
        end
        userCntB = 0;
        lastCntB = 0;
        startB   = 1'b1;
        nextCycle();
        startB = 1'b0;
        #1;
        for (int i = 0; i < 20000 && !doneB; i++) begin
            nextCycle();
            treadyB = 1'($urandom_range(0, 1));
            #1;
        end
        checkOutput("frameDoneSeenB", 32'(doneB), 32'd1);
        nextCycle();
        treadyB = 1'b1;
        #1;
        checkOutput("busyAfterFrameB",  32'(busyB),       32'd0);
        checkOutput("scoreboardEmptyB", 32'(sbB.size()),  32'd0);
        checkOutput("tuserCountB",      32'(userCntB),    32'd1);
        checkOutput("tlastCountB",      32'(lastCntB),    32'd16);

        nextCycle();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
